mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Single-port arbiter between i_cache_simple (miss fetch) and d_cache_simple (miss/uncached ld/st)
//  and the shared axi_interface. Replaces the combinational sel_i mux in mycpu_top.
//  Registers the granted request, holds it stable until mem_ready, and returns a one-cycle
//  registered response to the owner only. Drops stale requests on exception flush.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  D_FIRST     1   1: d-side wins simultaneous requests (older M-stage op), subject to fairness rule
// PORTS
//  clk          in   1       system clock (aclk)
//  rst          in   1       synchronous reset, active-high
//  flush        in   1       exception flush (|excepttypeM)
//  i_req        in   1       icache miss strobe (m_fetch)
//  i_addr       in   ADDR_W  icache line/word address (m_i_a)
//  i_ready      out  1       one-cycle pulse: i_rdata valid
//  i_rdata      out  DATA_W  fetched word
//  d_req        in   1       dcache strobe (m_ld_st)
//  d_write      in   1       1 store, 0 load (m_st)
//  d_addr       in   ADDR_W  data physical address (m_d_a)
//  d_size       in   2       0 byte, 1 half, 2 word
//  d_sel        in   4       byte strobes for stores
//  d_wdata      in   DATA_W  store data (m_din)
//  d_ready      out  1       one-cycle pulse: d access complete, d_rdata valid for loads
//  d_rdata      out  DATA_W  loaded word
//  mem_access   out  1       request to axi_interface
//  mem_a        out  ADDR_W  address
//  mem_write    out  1       write enable
//  mem_size     out  2       transfer size
//  mem_sel      out  4       byte strobes
//  mem_st_data  out  DATA_W  store data
//  mem_ready    in   1       axi_interface completion pulse
//  mem_data     in   DATA_W  read data, valid with mem_ready
//  busy         out  1       FSM not IDLE (debug/perf)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_d=0; kill=0.
//  States: IDLE, SERVE_I, SERVE_D, RESP.
//  IDLE: grant chosen from d_req&~flush and i_req. Both pending: D if D_FIRST&~last_d, else I
//   (last_d set when a D grant completes -> an I waiting behind a D is served next; no starvation).
//   On grant, capture addr/write/size/sel/wdata into request regs; next state SERVE_x.
//   I grant forces write=0, size=2, sel=4'b1111.
//  SERVE_x: mem_access=1 and mem_* driven from regs only (stable; requester inputs ignored).
//   mem_ready -> latch mem_data into rdata reg, -> RESP. flush in SERVE_x sets kill; transfer still
//   runs to mem_ready (AXI not aborted here).
//  RESP (1 cycle): mem_access=0; owner ready pulses unless kill; kill cleared; -> IDLE.
//   Granting resumes in IDLE, so issue-to-issue gap is 1 cycle.
//  Latency: grant cycle +1 = first mem_access cycle; ready pulses 1 cycle after mem_ready.
//  i_rdata/d_rdata hold value until next response of that side.
//  flush in IDLE with d_req high: no D grant; I may be granted same cycle.
//  flush coincident with mem_ready: response suppressed.
//  Requester drops req mid-SERVE: ignored, transfer completes, ready still pulses
//   (cache discards). Store completion: d_ready pulses, d_rdata don't-care.
//  rst mid-transfer: immediate IDLE, no pulses.
// STRUCTURE
//  Shared package (cpu_defs.vh): state encodings, SIZE_BYTE/HALF/WORD, GRANT_I/GRANT_D.
//  Single module; no sub-module.
// TESTING
//  i_req only, addr 0xBFC00000, mem_ready after 3 cyc with 0x3C080001
//   -> mem_access 3 cyc, size=2 sel=F; i_ready pulse 1 cyc later, i_rdata=0x3C080001; d_ready never.
//  i_req & d_req same cycle, D load 0x80001000
//   -> D served first; then I; d_ready before i_ready; each exactly one pulse.
//  d store addr 0x1FAF0000 sel=0011 data 0x1234ABCD, d_addr changed mid-SERVE
//   -> mem_a/sel/st_data unchanged until mem_ready; mem_write=1; d_ready pulse.
//  flush asserted 2 cyc into SERVE_D
//   -> mem_access held to mem_ready; no d_ready; next IDLE grants pending i_req.
//  flush and d_req same cycle in IDLE -> no grant, mem_access stays 0.
//  rst during SERVE_I -> next cycle all outputs 0, state IDLE, no i_ready.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: FSM states, grant owner,
// transfer size encodings and the tie-break rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // D wins a tie only when it did not win the previous completed transfer,
  // so an I miss queued behind a D access is never starved.
  function automatic logic d_wins(input logic d_ok, input logic i_req,
                                  input logic d_first, input logic last_d);
    return d_ok & (~i_req | (d_first & ~last_d));
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Registered arbiter between icache misses and dcache accesses onto the single
// axi_interface port; holds the granted request stable and returns a 1-cycle response.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int D_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic [3:0]        d_sel,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_access,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_sel,
  output logic [DATA_W-1:0] mem_st_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  localparam logic DF = (D_FIRST != 0);

  state_e            state_q, state_d;
  grant_e            owner_q, owner_d;
  logic              last_d_q, last_d_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_ok;
  logic              serving;

  assign d_ok    = d_req & ~flush;
  assign serving = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d_d  = last_d_q;
    kill_d    = kill_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (d_wins(d_ok, i_req, DF, last_d_q)) begin
          owner_d = GRANT_D;
          addr_d  = d_addr;
          write_d = d_write;
          size_d  = d_size;
          sel_d   = d_sel;
          wdata_d = d_wdata;
          state_d = ST_SERVE_D;
        end else if (i_req) begin
          owner_d = GRANT_I;
          addr_d  = i_addr;
          write_d = 1'b0;
          size_d  = SIZE_WORD;
          sel_d   = 4'b1111;
          wdata_d = '0;
          state_d = ST_SERVE_I;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        // The AXI transfer cannot be aborted; a flush only suppresses the response.
        if (flush) kill_d = 1'b1;
        if (mem_ready) begin
          if (!(kill_q || flush)) begin
            if (owner_q == GRANT_I) i_rdata_d = mem_data;
            else if (!write_q)      d_rdata_d = mem_data;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        kill_d   = 1'b0;
        last_d_d = (owner_q == GRANT_D);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= GRANT_I;
      last_d_q  <= 1'b0;
      kill_q    <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_d_q  <= last_d_d;
      kill_q    <= kill_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Memory side is driven purely from request registers, never from requester inputs.
  assign mem_access  = serving;
  assign mem_a       = addr_q;
  assign mem_write   = write_q;
  assign mem_size    = size_q;
  assign mem_sel     = sel_q;
  assign mem_st_data = wdata_q;

  assign i_ready = (state_q == ST_RESP) && (owner_q == GRANT_I) && !kill_q;
  assign d_ready = (state_q == ST_RESP) && (owner_q == GRANT_D) && !kill_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations, sampled on negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req, d_write;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_access;
  logic [31:0] mem_a;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;
  logic [31:0] mem_st_data;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int i_cnt, d_cnt, ma;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .D_FIRST(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_size(d_size),
    .d_sel(d_sel), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_access(mem_access), .mem_a(mem_a), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge and tally response pulses seen there.
  task automatic cyc();
    @(negedge clk);
    i_cnt += int'(i_ready);
    d_cnt += int'(d_ready);
  endtask

  // Called in the first SERVE cycle: completes after n access cycles, ends in RESP.
  task automatic respond(input int n, input logic [31:0] data);
    ma = 0;
    for (int k = 0; k < n; k++) begin
      ma += int'(mem_access);
      if (k == n - 1) begin
        mem_ready = 1'b1;
        mem_data  = data;
      end
      cyc();
    end
    mem_ready = 1'b0;
    mem_data  = 32'h0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_size = '0; d_sel = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_data = '0;
    i_cnt = 0; d_cnt = 0;
    cyc(); cyc();
    chk("rst_access", mem_access, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {i_ready, d_ready}, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    rst = 1'b0;
    cyc();

    // I fetch alone, three access cycles
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    i_cnt = 0; d_cnt = 0;
    cyc();
    chk("t1_access", mem_access, 1);
    chk("t1_addr", mem_a, 32'hBFC0_0000);
    chk("t1_size_sel_wr", {mem_size, mem_sel, mem_write}, {2'd2, 4'hF, 1'b0});
    chk("t1_ready_early", i_ready, 0);
    respond(3, 32'h3C08_0001);
    chk("t1_ma_cycles", ma, 3);
    chk("t1_i_ready", i_ready, 1);
    chk("t1_i_rdata", i_rdata, 32'h3C08_0001);
    chk("t1_access_resp", mem_access, 0);
    i_req = 1'b0;
    cyc();
    chk("t1_i_pulses", i_cnt, 1);
    chk("t1_d_pulses", d_cnt, 0);
    chk("t1_idle", busy, 0);

    // Simultaneous: D load served first, then I
    i_req = 1'b1; i_addr = 32'hBFC0_0004;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h8000_1000; d_size = 2'd2; d_sel = 4'hF;
    i_cnt = 0; d_cnt = 0;
    cyc();
    chk("t2_d_first", mem_a, 32'h8000_1000);
    respond(2, 32'hDEAD_BEEF);
    chk("t2_d_ready", {d_ready, i_ready}, 2'b10);
    chk("t2_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    cyc();
    chk("t2_gap_idle", mem_access, 0);
    cyc();
    chk("t2_i_addr", mem_a, 32'hBFC0_0004);
    chk("t2_d_cnt_mid", d_cnt, 1);
    chk("t2_i_cnt_mid", i_cnt, 0);
    respond(1, 32'h1111_2222);
    chk("t2_i_ready", {d_ready, i_ready}, 2'b01);
    chk("t2_i_rdata", i_rdata, 32'h1111_2222);
    i_req = 1'b0;
    cyc();
    chk("t2_pulses", {i_cnt[7:0], d_cnt[7:0]}, {8'd1, 8'd1});

    // D half store; requester inputs change mid-transfer
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h1FAF_0000; d_size = 2'd1;
    d_sel = 4'b0011; d_wdata = 32'h1234_ABCD;
    i_cnt = 0; d_cnt = 0;
    cyc();
    chk("t3_write", mem_write, 1);
    d_addr = 32'hDEAD_0000; d_sel = 4'hF; d_wdata = 32'h0; d_size = 2'd2;
    cyc();
    chk("t3_hold_a", mem_a, 32'h1FAF_0000);
    chk("t3_hold_sel_size", {mem_sel, mem_size}, {4'b0011, 2'd1});
    chk("t3_hold_data", mem_st_data, 32'h1234_ABCD);
    respond(2, 32'h0);
    chk("t3_ma", ma, 2);
    chk("t3_d_ready", d_ready, 1);
    d_req = 1'b0; d_write = 1'b0;
    cyc();
    chk("t3_pulses", {i_cnt[7:0], d_cnt[7:0]}, {8'd0, 8'd1});

    // Flush two cycles into SERVE_D, I waiting behind
    d_req = 1'b1; d_addr = 32'h8000_2000; d_size = 2'd2; d_sel = 4'hF;
    i_cnt = 0; d_cnt = 0;
    cyc();
    chk("t4_d_serve", mem_a, 32'h8000_2000);
    i_req = 1'b1; i_addr = 32'hBFC0_0100;
    cyc();
    flush = 1'b1; d_req = 1'b0;
    cyc();
    flush = 1'b0;
    chk("t4_access_held", mem_access, 1);
    respond(2, 32'h5555_5555);
    chk("t4_no_ready", {d_ready, i_ready}, 0);
    chk("t4_d_rdata_kept", d_rdata, 32'hDEAD_BEEF);
    cyc();
    chk("t4_idle", mem_access, 0);
    cyc();
    chk("t4_i_granted", {mem_access, mem_a}, {1'b1, 32'hBFC0_0100});
    respond(1, 32'h7777_7777);
    chk("t4_i_ready", i_ready, 1);
    i_req = 1'b0;
    cyc();
    chk("t4_pulses", {i_cnt[7:0], d_cnt[7:0]}, {8'd1, 8'd0});

    // Flush with d_req in IDLE: no grant
    d_req = 1'b1; flush = 1'b1;
    cyc();
    chk("t5_no_grant", {mem_access, busy}, 0);
    d_req = 1'b0; flush = 1'b0;
    cyc();
    chk("t5_still_idle", mem_access, 0);

    // Flush coincident with mem_ready: response suppressed
    i_req = 1'b1; i_addr = 32'hBFC0_0200;
    i_cnt = 0;
    cyc();
    mem_ready = 1'b1; mem_data = 32'h9999_9999; flush = 1'b1;
    cyc();
    mem_ready = 1'b0; flush = 1'b0; i_req = 1'b0;
    chk("t6_no_ready", i_ready, 0);
    chk("t6_rdata_kept", i_rdata, 32'h7777_7777);
    cyc();
    chk("t6_pulses", i_cnt, 0);

    // Reset during SERVE_I
    i_req = 1'b1; i_addr = 32'hBFC0_0300;
    i_cnt = 0;
    cyc();
    chk("t7_serving", mem_access, 1);
    rst = 1'b1; i_req = 1'b0;
    cyc();
    chk("t7_rst_outs", {mem_access, busy, i_ready, d_ready}, 0);
    chk("t7_rst_mem_a", mem_a, 0);
    chk("t7_rst_rdata", i_rdata, 0);
    rst = 1'b0;
    cyc();
    chk("t7_pulses", i_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
